i2c_target_regfile: RTL
=======================

// Module: i2c_target_regfile
// PURPOSE
//  I2C target (responder) that answers the I2C master on the shared SCL/SDA pair and serves a
//  byte-wide register file with an MPU-6050-style protocol: register-pointer write, burst write,
//  repeated-START burst read. Used as the on-chip bus partner for master bring-up, and as the
//  register front end for sensor-emulation logic. Runs entirely in the system clock domain.
// PARAMETERS
//  SLAVE_ADDR   7'h68  7-bit target address matched after START
//  NUM_REGS     16     implemented registers at addresses 0..NUM_REGS-1 (1..256)
// PORTS
//  clk        in   1  system clock; must be >= 8x SCL frequency
//  rst        in   1  asynchronous, active-high reset
//  scl        in   1  I2C clock from master (asynchronous)
//  sda_in     in   1  resolved SDA line level (asynchronous)
//  sda_out    out  1  SDA drive value; constant 0 (open-drain)
//  tristate   out  1  1 = SDA released, 0 = target pulls SDA low
//  loc_we     in   1  local write strobe (sensor side)
//  loc_addr   in   8  local write/read register address
//  loc_wdata  in   8  local write data
//  loc_rdata  out  8  combinational read of register[loc_addr]; 0 if out of range
//  wr_valid   out  1  one-cycle pulse: master wrote a data byte
//  wr_addr    out  8  register address of that byte
//  wr_data    out  8  data of that byte
//  busy       out  1  1 from address match until STOP or loss of selection
// BEHAVIOUR
//  Reset (async): tristate=1, sda_out=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, pointer=0,
//   all registers=0, state=IDLE. Reset mid-transfer releases SDA immediately.
//  scl/sda_in pass a 2-flop synchroniser, then edge detect; 3-cycle detection latency.
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high. START in any state -> ADDR
//   (repeated START); STOP in any state -> IDLE, tristate=1, busy=0.
//  SDA sampled on SCL rise; tristate changed only on the clk after SCL fall detection.
//  States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
//  ADDR: shift 8 bits MSB first; match [7:1]==SLAVE_ADDR -> ADDR_ACK (drive 0 for one SCL
//   period), busy=1; mismatch -> IGNORE (SDA released) until START/STOP.
//  After ACK: bit0=0 -> REG; bit0=1 -> RDATA.
//  REG: received byte loads the pointer, ACK -> WDATA.
//  WDATA: every byte ACKed; if pointer<NUM_REGS, register[pointer] written and wr_valid pulses
//   one cycle on the 8th SCL rise; out-of-range writes ACKed, discarded, no pulse. Pointer +1.
//  RDATA: register[pointer] (0 if out of range) latched at byte start, shifted MSB first; a
//   1 bit releases SDA, a 0 bit pulls low. Pointer +1 after the byte. RDATA_ACK: master ACK
//   (SDA=0) -> next byte; NACK -> IGNORE with SDA released.
//  Pointer is 8 bits, wraps 8'hFF -> 8'h00.
//  Simultaneous loc_we and I2C write to same address on same clk: I2C write wins.
//   Different addresses: both complete.
//  A read byte is snapshotted at byte start; a local write mid-byte affects the next read.
// CONFIGURATION
//  I2C_TGT_WHO_AM_I_EN defined: address 8'h75 is a read-only WHO_AM_I returning
//   {1'b0,SLAVE_ADDR}; I2C writes to it ACKed and discarded (no wr_valid); loc_rdata at 8'h75
//   returns the same. Not defined: 8'h75 is an ordinary address (out of range at defaults -> 0).
// STRUCTURE
//  Package i2c_tgt_pkg: state enum, WHO_AM_I_ADDR=8'h75, RW_WRITE=0/RW_READ=1, ACK=0/NACK=1.
//  Sub-module i2c_bus_sync: 2-flop synchronisers plus scl_rise, scl_fall, start_det, stop_det.
//  Top holds FSM, bit counter, shift register, pointer, register array.
// TESTING
//  Write: START,0xD0,0x03,0xA5,0x5A,STOP -> 4 ACKs; reg3=0xA5, reg4=0x5A; 2 wr_valid pulses.
//  Read: preload reg3/4, START,0xD0,0x03,Sr,0xD1, read 2 with ACK,NACK -> 0xA5,0x5A; SDA released.
//  Wrong address 0xA0 -> NACK; bus ignored until STOP; no register change; busy stays 0.
//  Pointer 0x0F burst write 3 bytes -> reg15 written; 0x10,0x11 ACKed, dropped; reads -> 0x00.
//  Macro on: read 0x75 -> 0x68; write 0x75 <- 0x00, read again -> still 0x68.
//  Assert rst during RDATA bit 4 -> tristate=1 same cycle; next transfer works from IDLE.

Source files
------------

// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_tgt_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_e;

  localparam logic [7:0] WHO_AM_I_ADDR = 8'h75;
  localparam logic       RW_WRITE      = 1'b0;
  localparam logic       RW_READ       = 1'b1;
  localparam logic       ACK           = 1'b0;
  localparam logic       NACK          = 1'b1;
endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges and START/STOP.
// Event pulses are registered, so any bus change is seen 3 clks later.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  // [0] metastable stage, [1] synchronised level, [2] previous level
  logic [2:0] scl_q, sda_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_q      <= '1;
      sda_q      <= '1;
      sda_o      <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_i};
      sda_q      <= {sda_q[1:0], sda_i};
      sda_o      <= sda_q[1];
      scl_rise_o <= scl_q[1] & ~scl_q[2];
      scl_fall_o <= ~scl_q[1] & scl_q[2];
      start_o    <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
      stop_o     <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    end
  end
endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target serving a byte register file (pointer write, burst write, burst read).
// Define I2C_TGT_WHO_AM_I_EN to make 8'h75 a read-only WHO_AM_I register.
module i2c_target_regfile
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h68,
  parameter int         NUM_REGS   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       tristate,
  input  logic       loc_we,
  input  logic [7:0] loc_addr,
  input  logic [7:0] loc_wdata,
  output logic [7:0] loc_rdata,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);
  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl),
    .sda_i      (sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_e     state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sh_q, sh_d, ptr_q, ptr_d;
  logic       tri_q, tri_d, busy_q, busy_d, rw_q, rw_d, ld_q, ld_d;
  logic       wrv_q, wrv_d;
  logic [7:0] wra_q, wra_d, wrd_q, wrd_d;
  logic       i2c_we, wr_ok;
  logic [7:0] byte_in, ptr_rd;
  logic [7:0] regs_q [NUM_REGS];

  function automatic logic [7:0] rd_reg(input logic [7:0] a);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == 8'(i)) r = regs_q[i];
`ifdef I2C_TGT_WHO_AM_I_EN
    if (a == WHO_AM_I_ADDR) r = {1'b0, SLAVE_ADDR};
`endif
    return r;
  endfunction

  assign byte_in   = {sh_q[6:0], sda_s};
  assign ptr_rd    = rd_reg(ptr_q);
  assign loc_rdata = rd_reg(loc_addr);
`ifdef I2C_TGT_WHO_AM_I_EN
  assign wr_ok = ({24'd0, ptr_q} < NUM_REGS) && (ptr_q != WHO_AM_I_ADDR);
`else
  assign wr_ok = ({24'd0, ptr_q} < NUM_REGS);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      tri_q   <= 1'b1;
      busy_q  <= 1'b0;
      rw_q    <= RW_WRITE;
      ld_q    <= 1'b0;
      wrv_q   <= 1'b0;
      wra_q   <= '0;
      wrd_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      tri_q   <= tri_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      ld_q    <= ld_d;
      wrv_q   <= wrv_d;
      wra_q   <= wra_d;
      wrd_q   <= wrd_d;
    end
  end

  // In the ACK states tri_q doubles as the phase: first SCL fall drives, second releases.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    tri_d   = tri_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    ld_d    = ld_q;
    wrv_d   = 1'b0;
    wra_d   = wra_q;
    wrd_d   = wrd_q;
    i2c_we  = 1'b0;
    if (stop_det) begin
      state_d = IDLE;
      tri_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      bcnt_d  = '0;
      tri_d   = 1'b1;
      ld_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d   = byte_in;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = byte_in[0];
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          bcnt_d = '0;
          if (tri_q) tri_d = ACK;
          else if (rw_q == RW_READ) begin
            state_d = RDATA;
            sh_d    = ptr_rd;
            tri_d   = ptr_rd[7];
          end else begin
            state_d = REG;
            tri_d   = 1'b1;
          end
        end
        REG: if (scl_rise) begin
          sh_d   = byte_in;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            ptr_d   = byte_in;
            state_d = REG_ACK;
          end
        end
        REG_ACK, WDATA_ACK: if (scl_fall) begin
          bcnt_d = '0;
          if (tri_q) tri_d = ACK;
          else begin
            tri_d   = 1'b1;
            state_d = WDATA;
          end
        end
        WDATA: if (scl_rise) begin
          sh_d   = byte_in;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            if (wr_ok) begin
              i2c_we = 1'b1;
              wrv_d  = 1'b1;
              wra_d  = ptr_q;
              wrd_d  = byte_in;
            end
            ptr_d   = ptr_q + 8'd1;
            state_d = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (ld_q) begin
              sh_d  = ptr_rd;
              tri_d = ptr_rd[7];
              ld_d  = 1'b0;
            end else begin
              sh_d  = {sh_q[6:0], 1'b0};
              tri_d = sh_q[6];
            end
          end
          if (scl_rise) begin
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              bcnt_d  = '0;
              ptr_d   = ptr_q + 8'd1;
              state_d = RDATA_ACK;
            end
          end
        end
        RDATA_ACK: begin
          if (scl_fall) tri_d = 1'b1;
          if (scl_rise) begin
            if (sda_s == ACK) begin
              state_d = RDATA;
              ld_d    = 1'b1;
            end else state_d = IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  // I2C write takes priority when both sides hit the same register in one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i2c_we && ptr_q == 8'(i)) regs_q[i] <= byte_in;
        else if (loc_we && loc_addr == 8'(i)) regs_q[i] <= loc_wdata;
      end
    end
  end

  assign sda_out  = 1'b0;
  assign tristate = tri_q;
  assign busy     = busy_q;
  assign wr_valid = wrv_q;
  assign wr_addr  = wra_q;
  assign wr_data  = wrd_q;
endmodule
